// File: rtl/cpath_pkg.sv
// Shared definitions for the RV32I multicycle control path: opcodes,
// FSM state encoding, select/trap-cause encodings and the decode bundle.
package cpath_pkg;

    // Base opcodes (IR[6:0]); every legal one ends in 2'b11.
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_MDIV  = 3'd3,
        ST_WB    = 3'd4,
        ST_TRAP  = 3'd5
    } state_e;

    localparam logic [1:0] BUS_B_RS2  = 2'b00;
    localparam logic [1:0] BUS_B_IIMM = 2'b01;
    localparam logic [1:0] BUS_B_SIMM = 2'b10;
    localparam logic [1:0] BUS_B_UIMM = 2'b11;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;
    localparam logic [1:0] WB_MULDIV = 2'b11;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_BRJMP = 2'b01;
    localparam logic [1:0] PC_TRAP  = 2'b10;
    localparam logic [1:0] PC_HOLD  = 2'b11;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_BUS  = 2'b10;

    // Everything the FSM needs to know about one instruction.
    typedef struct packed {
        logic       bus_a_sel;
        logic [1:0] bus_b_sel;
        logic [1:0] wb_sel;
        logic       brjmp_sel;
        logic       jbtype_sel;
        logic       reg_wen;     // already cleared when rd == x0
        logic       is_branch;
        logic       is_jump;
        logic       mem_rd;
        logic       mem_wr;
        logic       is_muldiv;
        logic       illegal;
    } dec_t;

    // Branch condition: funct3[2:1] picks the flag, funct3[0] inverts it.
    function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                          input logic lt, input logic ltu);
        logic t;
        case (f3[2:1])
            2'b00:   t = eq;
            2'b10:   t = lt;
            2'b11:   t = ltu;
            default: t = 1'b0;
        endcase
        return t ^ f3[0];
    endfunction

endpackage

// File: rtl/cpath_decode_comb.sv
// Pure combinational decode of a registered instruction word into the
// select bundle and an illegal flag. Macro RV_MEXT_EN makes OP with
// funct7=0000001 a legal multiply/divide; otherwise it is illegal.
module cpath_decode_comb
    import cpath_pkg::*;
(
    input  logic [31:0] ir_i,
    output dec_t        dec_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic       unused_fields;

    assign opc = ir_i[6:0];
    assign f3  = ir_i[14:12];
    assign f7  = ir_i[31:25];
    assign rd  = ir_i[11:7];
    // Register source fields are consumed by the datapath, not by decode.
    assign unused_fields = ^ir_i[24:15];

    // Opcode/funct decode; anything with IR[1:0]!=11 falls to the default arm.
    always_comb begin
        dec_o = '0;
        case (opc)
            OPC_LUI: begin
                dec_o.bus_b_sel = BUS_B_UIMM;
                dec_o.reg_wen   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.bus_a_sel = 1'b1;
                dec_o.bus_b_sel = BUS_B_UIMM;
                dec_o.reg_wen   = 1'b1;
            end
            OPC_JAL: begin
                dec_o.brjmp_sel = 1'b1;
                dec_o.wb_sel    = WB_PC4;
                dec_o.reg_wen   = 1'b1;
                dec_o.is_jump   = 1'b1;
            end
            OPC_JALR: begin
                if (f3 != 3'b000) begin
                    dec_o.illegal = 1'b1;
                end else begin
                    dec_o.brjmp_sel  = 1'b1;
                    dec_o.jbtype_sel = 1'b1;
                    dec_o.bus_b_sel  = BUS_B_IIMM;
                    dec_o.wb_sel     = WB_PC4;
                    dec_o.reg_wen    = 1'b1;
                    dec_o.is_jump    = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (f3[2:1] == 2'b01) dec_o.illegal   = 1'b1;
                else                  dec_o.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                if (f3 == 3'b011 || f3[2:1] == 2'b11) begin
                    dec_o.illegal = 1'b1;
                end else begin
                    dec_o.bus_b_sel = BUS_B_IIMM;
                    dec_o.wb_sel    = WB_MEM;
                    dec_o.reg_wen   = 1'b1;
                    dec_o.mem_rd    = 1'b1;
                end
            end
            OPC_STORE: begin
                if (f3[2] || f3[1:0] == 2'b11) begin
                    dec_o.illegal = 1'b1;
                end else begin
                    dec_o.bus_b_sel = BUS_B_SIMM;
                    dec_o.mem_wr    = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if ((f3 == 3'b001 && f7 != F7_BASE) ||
                    (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)) begin
                    dec_o.illegal = 1'b1;
                end else begin
                    dec_o.bus_b_sel = BUS_B_IIMM;
                    dec_o.reg_wen   = 1'b1;
                end
            end
            OPC_OP: begin
                if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec_o.reg_wen = 1'b1;
                end else if (f7 == F7_MEXT) begin
`ifdef RV_MEXT_EN
                    dec_o.is_muldiv = 1'b1;
                    dec_o.wb_sel    = WB_MULDIV;
                    dec_o.reg_wen   = 1'b1;
`else
                    dec_o.illegal = 1'b1;
`endif
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            // FENCE has no effect on a single in-order core: retire as NOP.
            OPC_MISCMEM: ;
            default: dec_o.illegal = 1'b1;
        endcase
        // An illegal word must not leak any select or strobe.
        if (dec_o.illegal) begin
            dec_o         = '0;
            dec_o.illegal = 1'b1;
        end
        if (rd == 5'd0) dec_o.reg_wen = 1'b0;
    end

endmodule

// File: rtl/cpath_ctrl_fsm.sv
// Multicycle RV32I control FSM: FETCH -> EXEC -> {MEM | MDIV} -> WB -> FETCH,
// with TRAP for illegal ops and data-memory timeouts. Optional M-extension
// sequencing is enabled with macro RV_MEXT_EN.
module cpath_ctrl_fsm
    import cpath_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter bit          TRAP_ON_ILL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_IR,
    input  logic        io_IR_valid,
    output logic        io_IR_ready,
    input  logic        io_br_eq,
    input  logic        io_br_lt,
    input  logic        io_br_ltu,
    input  logic        io_DataMem_rdy,
    input  logic        io_MulDiv_done,
    output logic        io_BUS_A_sel,
    output logic [1:0]  io_BUS_B_sel,
    output logic [1:0]  io_WB_sel,
    output logic        io_BRJMP_sel,
    output logic        io_JBType_sel,
    output logic [1:0]  io_PC_MUX_sel,
    output logic        io_PC_en,
    output logic        io_WEN_RegFile,
    output logic        io_Mem_rd,
    output logic        io_Mem_wr_valid,
    output logic [1:0]  io_Mem_size,
    output logic        io_Mem_unsigned,
    output logic        io_MulDiv_start,
    output logic        io_trap,
    output logic [1:0]  io_trap_cause,
    output logic [2:0]  dbg_state_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    // Handshake: io_IR is captured on the rising edge where io_IR_valid and
    // io_IR_ready are both high; ready is high only in FETCH and does not
    // depend on valid, so fetch may hold valid across cycles freely.

    state_e             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               taken_q, taken_d;
    logic [1:0]         cause_q, cause_d;
    logic               mdiv_first_q, mdiv_first_d;
    logic               sel_en;
    dec_t               dec;

    cpath_decode_comb u_decode (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    assign dbg_state_o   = state_q;
    assign io_trap_cause = cause_q;

`ifndef RV_MEXT_EN
    logic unused_mdiv;
    assign unused_mdiv = io_MulDiv_done ^ mdiv_first_q;
`endif

    // State and instruction registers; reset aborts any op without writeback.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FETCH;
            ir_q         <= '0;
            cnt_q        <= '0;
            taken_q      <= 1'b0;
            cause_q      <= CAUSE_NONE;
            mdiv_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            cnt_q        <= cnt_d;
            taken_q      <= taken_d;
            cause_q      <= cause_d;
            mdiv_first_q <= mdiv_first_d;
        end
    end

    // Next-state logic and all control outputs.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        cnt_d        = cnt_q;
        taken_d      = taken_q;
        cause_d      = cause_q;
        mdiv_first_d = 1'b0;

        io_IR_ready     = 1'b0;
        io_BUS_A_sel    = 1'b0;
        io_BUS_B_sel    = BUS_B_RS2;
        io_WB_sel       = WB_ALU;
        io_BRJMP_sel    = 1'b0;
        io_JBType_sel   = 1'b0;
        io_PC_MUX_sel   = PC_HOLD;
        io_PC_en        = 1'b0;
        io_WEN_RegFile  = 1'b0;
        io_Mem_rd       = 1'b0;
        io_Mem_wr_valid = 1'b0;
        io_Mem_size     = 2'b00;
        io_Mem_unsigned = 1'b0;
        io_MulDiv_start = 1'b0;
        io_trap         = 1'b0;

        // Datapath selects follow the decoded IR while an op is in flight.
        sel_en = (state_q != ST_FETCH) && (state_q != ST_TRAP);
        if (sel_en) begin
            io_BUS_A_sel  = dec.bus_a_sel;
            io_BUS_B_sel  = dec.bus_b_sel;
            io_WB_sel     = dec.wb_sel;
            io_BRJMP_sel  = dec.brjmp_sel;
            io_JBType_sel = dec.jbtype_sel;
            io_PC_MUX_sel = taken_q ? PC_BRJMP : PC_PLUS4;
        end

        case (state_q)
            ST_FETCH: begin
                io_IR_ready = 1'b1;
                if (io_IR_valid) begin
                    ir_d    = io_IR;
                    taken_d = 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                taken_d = dec.is_jump |
                          (dec.is_branch & branch_taken(ir_q[14:12], io_br_eq, io_br_lt, io_br_ltu));
                io_PC_MUX_sel = taken_d ? PC_BRJMP : PC_PLUS4;
                if (dec.illegal) begin
                    if (TRAP_ON_ILL) begin
                        cause_d = CAUSE_ILL;
                        state_d = ST_TRAP;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (dec.mem_rd || dec.mem_wr) begin
                    cnt_d   = '0;
                    state_d = ST_MEM;
                end else if (dec.is_muldiv) begin
                    mdiv_first_d = 1'b1;
                    state_d      = ST_MDIV;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                io_Mem_rd       = dec.mem_rd;
                io_Mem_wr_valid = dec.mem_wr;
                io_Mem_size     = ir_q[13:12];
                io_Mem_unsigned = ir_q[14] & dec.mem_rd;
                if (io_DataMem_rdy) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(MEM_TIMEOUT)) begin
                        cause_d = CAUSE_BUS;
                        state_d = ST_TRAP;
                    end
                end
            end
            ST_MDIV: begin
`ifdef RV_MEXT_EN
                io_MulDiv_start = mdiv_first_q;
                if (io_MulDiv_done) state_d = ST_WB;
`else
                state_d = ST_FETCH;
`endif
            end
            ST_WB: begin
                io_WEN_RegFile = dec.reg_wen;
                io_PC_en       = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_TRAP: begin
                io_trap       = 1'b1;
                io_PC_MUX_sel = PC_TRAP;
                io_PC_en      = 1'b1;
                state_d       = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_cpath_ctrl_fsm.sv
// Directed bench for cpath_ctrl_fsm with hand-computed expectations.
// Build with RV_MEXT_EN defined to exercise the multiply/divide path.
module tb_cpath_ctrl_fsm;

    localparam int TMO = 6;

    logic        clock;
    logic        reset;
    logic [31:0] io_IR;
    logic        io_IR_valid;
    logic        io_IR_ready;
    logic        io_br_eq, io_br_lt, io_br_ltu;
    logic        io_DataMem_rdy;
    logic        io_MulDiv_done;
    logic        io_BUS_A_sel;
    logic [1:0]  io_BUS_B_sel;
    logic [1:0]  io_WB_sel;
    logic        io_BRJMP_sel;
    logic        io_JBType_sel;
    logic [1:0]  io_PC_MUX_sel;
    logic        io_PC_en;
    logic        io_WEN_RegFile;
    logic        io_Mem_rd;
    logic        io_Mem_wr_valid;
    logic [1:0]  io_Mem_size;
    logic        io_Mem_unsigned;
    logic        io_MulDiv_start;
    logic        io_trap;
    logic [1:0]  io_trap_cause;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    // Observations collected over one instruction.
    int o_cycles, o_wen, o_wbsel, o_pcen, o_pcmux_pcen, o_pcmux_exec;
    int o_trap, o_cause, o_mem_rd, o_mem_wr, o_size, o_uns, o_start;
    int o_bus_a, o_bus_b, o_brjmp, o_jbtype;

    cpath_ctrl_fsm #(.MEM_TIMEOUT(TMO), .TRAP_ON_ILL(1'b1)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_IR           (io_IR),
        .io_IR_valid     (io_IR_valid),
        .io_IR_ready     (io_IR_ready),
        .io_br_eq        (io_br_eq),
        .io_br_lt        (io_br_lt),
        .io_br_ltu       (io_br_ltu),
        .io_DataMem_rdy  (io_DataMem_rdy),
        .io_MulDiv_done  (io_MulDiv_done),
        .io_BUS_A_sel    (io_BUS_A_sel),
        .io_BUS_B_sel    (io_BUS_B_sel),
        .io_WB_sel       (io_WB_sel),
        .io_BRJMP_sel    (io_BRJMP_sel),
        .io_JBType_sel   (io_JBType_sel),
        .io_PC_MUX_sel   (io_PC_MUX_sel),
        .io_PC_en        (io_PC_en),
        .io_WEN_RegFile  (io_WEN_RegFile),
        .io_Mem_rd       (io_Mem_rd),
        .io_Mem_wr_valid (io_Mem_wr_valid),
        .io_Mem_size     (io_Mem_size),
        .io_Mem_unsigned (io_Mem_unsigned),
        .io_MulDiv_start (io_MulDiv_start),
        .io_trap         (io_trap),
        .io_trap_cause   (io_trap_cause),
        .dbg_state_o     (dbg_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issue one instruction from FETCH and follow it back to FETCH.
    // rdy_at: MEM cycle (1-based) in which rdy is raised, 0 = never.
    // done_at: MDIV cycle in which done is raised.
    task automatic run_instr(input logic [31:0] ir, input logic eq, input logic lt,
                             input logic ltu, input int rdy_at, input int done_at);
        int mem_cyc;
        int md_cyc;
        bit first;
        io_IR = ir; io_IR_valid = 1'b1;
        io_br_eq = eq; io_br_lt = lt; io_br_ltu = ltu;
        @(negedge clock);
        io_IR_valid = 1'b0;
        o_cycles = 1; o_wen = 0; o_wbsel = 0; o_pcen = 0; o_pcmux_pcen = 0; o_pcmux_exec = 0;
        o_trap = 0; o_cause = 0; o_mem_rd = 0; o_mem_wr = 0; o_size = 0; o_uns = 0; o_start = 0;
        o_bus_a = 0; o_bus_b = 0; o_brjmp = 0; o_jbtype = 0;
        mem_cyc = 0; md_cyc = 0; first = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (io_IR_ready) break;
            o_cycles++;
            if (first) begin
                o_pcmux_exec = io_PC_MUX_sel; o_bus_a = io_BUS_A_sel; o_bus_b = io_BUS_B_sel;
                o_brjmp = io_BRJMP_sel; o_jbtype = io_JBType_sel;
                first = 1'b0;
            end
            if (io_WEN_RegFile) begin o_wen++; o_wbsel = io_WB_sel; end
            if (io_PC_en) begin o_pcen++; o_pcmux_pcen = io_PC_MUX_sel; end
            if (io_trap) begin o_trap++; o_cause = io_trap_cause; end
            if (io_Mem_rd) begin o_mem_rd++; o_size = io_Mem_size; o_uns = io_Mem_unsigned; end
            if (io_Mem_wr_valid) begin o_mem_wr++; o_size = io_Mem_size; end
            if (io_Mem_rd || io_Mem_wr_valid) begin
                mem_cyc++;
                io_DataMem_rdy = (mem_cyc == rdy_at);
            end else begin
                io_DataMem_rdy = 1'b0;
            end
            if (io_MulDiv_start) begin o_start++; md_cyc = 1; end
            else if (md_cyc > 0) md_cyc++;
            io_MulDiv_done = (md_cyc > 0) && (md_cyc == done_at);
            @(negedge clock);
        end
        check_eq("back_to_fetch", io_IR_ready, 1);
        io_DataMem_rdy = 1'b0;
        io_MulDiv_done = 1'b0;
    endtask

    // Expected outcome common to every instruction.
    task automatic expect_core(input string tag, input int cyc, input int wen,
                               input int pcmux, input int trap, input int cause);
        check_eq({tag, "_cycles"}, o_cycles, cyc);
        check_eq({tag, "_wen"}, o_wen, wen);
        check_eq({tag, "_pcen"}, o_pcen, 1);
        check_eq({tag, "_pcmux"}, o_pcmux_pcen, pcmux);
        check_eq({tag, "_trap"}, o_trap, trap);
        if (trap != 0) check_eq({tag, "_cause"}, o_cause, cause);
    endtask

    initial begin
        reset = 1'b0; io_IR = '0; io_IR_valid = 1'b0;
        io_br_eq = 1'b0; io_br_lt = 1'b0; io_br_ltu = 1'b0;
        io_DataMem_rdy = 1'b0; io_MulDiv_done = 1'b0;

        @(negedge clock);
        check_eq("rst_ready", io_IR_ready, 1);
        check_eq("rst_pcmux", io_PC_MUX_sel, 2'b11);
        check_eq("rst_wen", io_WEN_RegFile, 0);
        check_eq("rst_pcen", io_PC_en, 0);
        check_eq("rst_cause", io_trap_cause, 0);
        check_eq("rst_state", dbg_state, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // ADD x3,x1,x2
        run_instr(32'h002081B3, 0, 0, 0, 0, 0);
        expect_core("add", 3, 1, 2'b00, 0, 0);
        check_eq("add_wbsel", o_wbsel, 2'b00);
        check_eq("add_busb", o_bus_b, 2'b00);

        // LW x5,0(x1), rdy on 4th MEM cycle
        run_instr(32'h0000A283, 0, 0, 0, 4, 0);
        expect_core("lw", 7, 1, 2'b00, 0, 0);
        check_eq("lw_memrd", o_mem_rd, 4);
        check_eq("lw_size", o_size, 2'b10);
        check_eq("lw_wbsel", o_wbsel, 2'b01);
        check_eq("lw_busb", o_bus_b, 2'b01);

        // BEQ taken / not taken
        run_instr(32'h00000463, 1, 0, 0, 0, 0);
        expect_core("beq_t", 3, 0, 2'b01, 0, 0);
        check_eq("beq_t_exec", o_pcmux_exec, 2'b01);
        check_eq("beq_t_brjmp", o_brjmp, 0);
        run_instr(32'h00000463, 0, 0, 0, 0, 0);
        expect_core("beq_n", 3, 0, 2'b00, 0, 0);
        check_eq("beq_n_exec", o_pcmux_exec, 2'b00);

        // BNE, BLTU, BGE condition polarity
        run_instr(32'h00001463, 1, 0, 0, 0, 0);
        check_eq("bne_eq1", o_pcmux_pcen, 2'b00);
        run_instr(32'h00001463, 0, 0, 0, 0, 0);
        check_eq("bne_eq0", o_pcmux_pcen, 2'b01);
        run_instr(32'h00006463, 0, 0, 1, 0, 0);
        check_eq("bltu_t", o_pcmux_pcen, 2'b01);
        run_instr(32'h00005463, 0, 1, 0, 0, 0);
        check_eq("bge_lt1", o_pcmux_pcen, 2'b00);

        // JALR x1,0(x1) and JAL x1,0
        run_instr(32'h000080E7, 0, 0, 0, 0, 0);
        expect_core("jalr", 3, 1, 2'b01, 0, 0);
        check_eq("jalr_jbtype", o_jbtype, 1);
        check_eq("jalr_brjmp", o_brjmp, 1);
        check_eq("jalr_wbsel", o_wbsel, 2'b10);
        run_instr(32'h000000EF, 0, 0, 0, 0, 0);
        expect_core("jal", 3, 1, 2'b01, 0, 0);
        check_eq("jal_jbtype", o_jbtype, 0);
        check_eq("jal_brjmp", o_brjmp, 1);

        // LUI / AUIPC operand selects
        run_instr(32'h123452B7, 0, 0, 0, 0, 0);
        check_eq("lui_busb", o_bus_b, 2'b11);
        check_eq("lui_busa", o_bus_a, 0);
        run_instr(32'h12345297, 0, 0, 0, 0, 0);
        check_eq("auipc_busa", o_bus_a, 1);
        check_eq("auipc_wen", o_wen, 1);

        // ADD x0: write suppressed, still retires
        run_instr(32'h00208033, 0, 0, 0, 0, 0);
        expect_core("add_x0", 3, 0, 2'b00, 0, 0);

        // Illegal encodings
        run_instr(32'h00000000, 0, 0, 0, 0, 0);
        expect_core("ill_zero", 3, 0, 2'b10, 1, 2'b01);
        run_instr(32'h002081B0, 0, 0, 0, 0, 0);
        expect_core("ill_lowbits", 3, 0, 2'b10, 1, 2'b01);
        run_instr(32'h402091B3, 0, 0, 0, 0, 0);
        expect_core("ill_funct7", 3, 0, 2'b10, 1, 2'b01);
        run_instr(32'h00002463, 0, 0, 0, 0, 0);
        expect_core("ill_br_f3", 3, 0, 2'b10, 1, 2'b01);

        // SW with rdy never high: bus timeout after TMO MEM cycles
        run_instr(32'h0020A023, 0, 0, 0, 0, 0);
        expect_core("sw_tmo", 3 + TMO, 0, 2'b10, 1, 2'b10);
        check_eq("sw_tmo_wr", o_mem_wr, TMO);
        check_eq("sw_busb", o_bus_b, 2'b10);

        // Cause held across a normal instruction
        run_instr(32'h002081B3, 0, 0, 0, 0, 0);
        check_eq("cause_held", io_trap_cause, 2'b10);

        // rdy on the timeout cycle completes normally
        run_instr(32'h0000A283, 0, 0, 0, TMO, 0);
        expect_core("lw_edge", 3 + TMO, 1, 2'b00, 0, 0);
        check_eq("lw_edge_rd", o_mem_rd, TMO);

        // LBU with rdy in first MEM cycle
        run_instr(32'h0000C283, 0, 0, 0, 1, 0);
        expect_core("lbu", 4, 1, 2'b00, 0, 0);
        check_eq("lbu_size", o_size, 2'b00);
        check_eq("lbu_uns", o_uns, 1);

        // MUL x3,x1,x2
        run_instr(32'h022081B3, 0, 0, 0, 0, 3);
`ifdef RV_MEXT_EN
        expect_core("mul", 6, 1, 2'b00, 0, 0);
        check_eq("mul_start", o_start, 1);
        check_eq("mul_wbsel", o_wbsel, 2'b11);
`else
        expect_core("mul_ill", 3, 0, 2'b10, 1, 2'b01);
        check_eq("mul_start", o_start, 0);
`endif

        // Reset asserted mid-MEM
        io_IR = 32'h0000A283; io_IR_valid = 1'b1;
        @(negedge clock);
        io_IR_valid = 1'b0;
        @(negedge clock);
        check_eq("rstmem_pre_rd", io_Mem_rd, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rstmem_ready", io_IR_ready, 1);
        check_eq("rstmem_rd", io_Mem_rd, 0);
        check_eq("rstmem_pcmux", io_PC_MUX_sel, 2'b11);
        check_eq("rstmem_wen", io_WEN_RegFile, 0);
        check_eq("rstmem_cause", io_trap_cause, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_instr(32'h002081B3, 0, 0, 0, 0, 0);
        expect_core("post_rst_add", 3, 1, 2'b00, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
